// File: rtl/decode_register_file_pkg.sv
// Shared RISC-V types and constants for the decode-stage register file.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/decode_register_file_if.sv
// Write-back / decode port bundle of the integer register file.
interface decode_register_file_if import riscv_pkg::*; #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32
);
  localparam int IW = $clog2(NREGS);

  logic            RegWriteW;
  logic [IW-1:0]   RdW;
  logic [XLEN-1:0] ResultW;
  logic [IW-1:0]   A1D;
  logic [IW-1:0]   A2D;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [15:0]     WrCountW;

  modport master (
    output RegWriteW, RdW, ResultW, A1D, A2D,
    input  RD1D, RD2D, WrCountW
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, A1D, A2D,
    output RD1D, RD2D, WrCountW
  );
endinterface

// File: rtl/decode_register_file_read_port.sv
// One combinational read port: index decode, x0 forcing, optional write bypass.
// Bypass is compiled in when RF_BYPASS_EN is defined.
module regfile_read_port import riscv_pkg::*; #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int IW    = $clog2(NREGS)
) (
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [IW-1:0]   addr,
  input  logic            byp_we,
  input  logic [IW-1:0]   byp_rd,
  input  logic [XLEN-1:0] byp_data,
  output logic [XLEN-1:0] data
);
  logic addr_ok;

  assign addr_ok = (addr != IW'(REG_ZERO)) && (int'(addr) < NREGS);

`ifdef RF_BYPASS_EN
  always_comb begin
    data = '0;
    if (addr_ok) begin
      data = regs[addr];
      // write-first: a same-cycle write to this index wins over storage
      if (byp_we && (byp_rd == addr))
        data = byp_data;
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_we, byp_rd, byp_data};

  always_comb begin
    data = '0;
    if (addr_ok)
      data = regs[addr];
  end
`endif
endmodule

// File: rtl/decode_register_file.sv
// Integer register file: write-back writes, decode reads two ports combinationally.
// Optional same-cycle bypass: define RF_BYPASS_EN.
module decode_register_file import riscv_pkg::*; #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32
) (
  input logic clk,
  input logic reset,
  decode_register_file_if.slave rf
);
  localparam int IW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [15:0]     wr_count;
  logic            commit;
  logic            byp_we;

  assign commit = rf.RegWriteW && (rf.RdW != IW'(REG_ZERO)) && (int'(rf.RdW) < NREGS);
  // reset must force reads to 0 even while a write is being presented
  assign byp_we = rf.RegWriteW && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      wr_count <= '0;
    end else if (commit) begin
      regs[rf.RdW] <= rf.ResultW;
      if (wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
    end
  end

  assign rf.WrCountW = wr_count;

  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .IW(IW)) u_rp1 (
    .regs     (regs),
    .addr     (rf.A1D),
    .byp_we   (byp_we),
    .byp_rd   (rf.RdW),
    .byp_data (rf.ResultW),
    .data     (rf.RD1D)
  );

  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .IW(IW)) u_rp2 (
    .regs     (regs),
    .addr     (rf.A2D),
    .byp_we   (byp_we),
    .byp_rd   (rf.RdW),
    .byp_data (rf.ResultW),
    .data     (rf.RD2D)
  );
endmodule

// File: tb/tb_decode_register_file.sv
// Scoreboard bench for decode_register_file: stimulus pushes expectations, negedge monitor checks.
module tb_decode_register_file;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  decode_register_file_if rf_if ();

  decode_register_file dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".rd1"}, rf_if.RD1D, e.r1);
      chk({e.name, ".rd2"}, rf_if.RD2D, e.r2);
      chk({e.name, ".cnt"}, {16'h0, rf_if.WrCountW}, {16'h0, e.cnt});
    end
  end

  task automatic cyc(input logic rst, input logic we, input logic [4:0] rd,
                     input logic [31:0] res, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    reset           = rst;
    rf_if.RegWriteW = we;
    rf_if.RdW       = rd;
    rf_if.ResultW   = res;
    rf_if.A1D       = a1;
    rf_if.A2D       = a2;
  endtask

  task automatic ex(input string n, input logic [31:0] r1, input logic [31:0] r2, input logic [15:0] c);
    exp_t e;
    e.name = n;
    e.r1   = r1;
    e.r2   = r2;
    e.cnt  = c;
    q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [4:0] rd;
    rf_if.RegWriteW = 1'b0;
    rf_if.RdW       = '0;
    rf_if.ResultW   = '0;
    rf_if.A1D       = '0;
    rf_if.A2D       = '0;

    cyc(1, 0, 0, 0, 5, 31);           ex("rst_init", 0, 0, 0);
    cyc(0, 1, 5, 32'h55, 5, 31);      ex("wr5", BYP ? 32'h55 : 32'h0, 0, 0);
    cyc(0, 1, 31, 32'h31F, 5, 31);    ex("wr31", 32'h55, BYP ? 32'h31F : 32'h0, 1);
    cyc(0, 0, 0, 0, 5, 31);           ex("rd5_31", 32'h55, 32'h31F, 2);

    // asynchronous reset mid-cycle, checked before the next edge
    cyc(0, 0, 0, 0, 5, 31);
    #2 reset = 1'b1;                  ex("rst_async", 0, 0, 0);

    cyc(0, 1, 7, 32'hDEADBEEF, 0, 0); ex("wr7", 0, 0, 0);
    cyc(0, 0, 0, 0, 7, 0);            ex("rd7", 32'hDEADBEEF, 0, 1);

    cyc(0, 1, 0, 32'h12345678, 0, 7); ex("wr_x0", 0, 32'hDEADBEEF, 1);
    cyc(0, 0, 0, 0, 0, 7);            ex("rd_x0", 0, 32'hDEADBEEF, 1);

    cyc(0, 1, 3, 32'h1, 3, 7);        ex("wr3a", BYP ? 32'h1 : 32'h0, 32'hDEADBEEF, 1);
    cyc(0, 1, 3, 32'h2, 3, 3);        ex("same_cyc", BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 2);
    cyc(0, 0, 0, 0, 3, 3);            ex("after_edge", 32'h2, 32'h2, 3);

    cyc(0, 1, 31, 32'hFFFFFFFF, 31, 1); ex("wr31b", BYP ? 32'hFFFFFFFF : 32'h0, 0, 3);
    cyc(0, 1, 1, 32'h80000001, 31, 1);  ex("wr1", 32'hFFFFFFFF, BYP ? 32'h80000001 : 32'h0, 4);
    cyc(0, 0, 0, 0, 31, 1);             ex("rd31_1", 32'hFFFFFFFF, 32'h80000001, 5);

    // write presented while reset is asserted is lost
    cyc(0, 1, 9, 32'hA5A5A5A5, 9, 3);
    #1 reset = 1'b1;                  ex("rst_wr", 0, 0, 0);
    cyc(0, 0, 0, 0, 9, 3);            ex("rd9_after", 0, 0, 0);
    cyc(0, 1, 9, 32'h9, 9, 0);        ex("first_wr", BYP ? 32'h9 : 32'h0, 0, 0);
    cyc(0, 0, 0, 0, 9, 0);            ex("rd9_commit", 32'h9, 0, 1);

    cyc(1, 0, 0, 0, 0, 0);            ex("rst_sat", 0, 0, 0);
    for (int i = 0; i <= 65536; i++) begin
      rd = 5'((i % 31) + 1);
      cyc(0, 1, rd, i, 0, 0);
      if (i == 0 || i == 1 || i == 65534 || i == 65535 || i == 65536)
        ex($sformatf("sat_%0d", i), 0, 0, (i > 65535) ? 16'hFFFF : 16'(i));
    end
    cyc(0, 0, 0, 0, 3, 2);            ex("sat_final", 32'h10000, 32'hFFFF, 16'hFFFF);
    cyc(0, 1, 4, 32'h4, 0, 0);        ex("sat_hold_wr", 0, 0, 16'hFFFF);
    cyc(0, 0, 0, 0, 4, 0);            ex("sat_hold", 32'h4, 0, 16'hFFFF);

    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_register_file.md
# decode_register_file

Integer register file for the five-stage RISC-V pipeline. The write-back stage writes it and the decode stage reads it. It takes the registered write-back controls (`RegWriteW`), the destination index and the result word, and serves two combinational read ports to decode. An optional same-cycle write-to-read bypass removes the WB→ID structural hazard, so the hazard unit never needs to stall for it.

## Interface
Parameters:
- `XLEN`, 32: data word width.
- `NREGS`, 32: architectural register count; index width is `$clog2(NREGS)`.

Ports:
- `clk`, in, 1: single clock, rising-edge active.
- `reset`, in, 1: asynchronous, active-high reset; clears every register.
- `RegWriteW`, in, 1: write enable from the write-back stage.
- `RdW`, in, `$clog2(NREGS)`: destination register index.
- `ResultW`, in, `XLEN`: write data selected by `ResultSrcW`.
- `A1D`, in, `$clog2(NREGS)`: read port 1 index (rs1).
- `A2D`, in, `$clog2(NREGS)`: read port 2 index (rs2).
- `RD1D`, out, `XLEN`: read port 1 data.
- `RD2D`, out, `XLEN`: read port 2 data.
- `WrCountW`, out, 16: saturating count of committed writes, for debug and performance.

## Operation
- Storage holds `NREGS` × `XLEN` flops. Entry 0 is never written and always reads 0.
- **Write:** on the rising edge of `clk`, if `RegWriteW=1` and `RdW≠0`, then `regs[RdW] <= ResultW`. Writes with `RdW=0` are discarded and are not counted.
- **Read:** `RD1D`/`RD2D` are combinational from `A1D`/`A2D` and the current storage (plus the bypass when enabled). Index 0 returns 0 unconditionally.
- **Counter:** `WrCountW` increments by 1 on each committed write. It saturates at `16'hFFFF` and does not wrap.
- **Reset:** asserting `reset` immediately, without waiting for a clock edge, does the following:
  - all entries go to 0;
  - `WrCountW` goes to 0;
  - `RD1D`/`RD2D` read 0 for any index.
- **Reset mid-operation:** a write presented in the same cycle that `reset` is asserted is lost.
- **Deassertion:** the first write can commit at the first rising edge after `reset` falls.
- **Out-of-range index:** when `NREGS` is not a power of two, an index ≥ `NREGS` reads 0 and a write to it is ignored.

## Timing
- Write latency is 1 edge: data written at edge N is visible from storage after edge N.
- Read latency is 0 cycles (combinational).
- **Same-cycle read/write to the same index, `RF_BYPASS_EN` defined:** the read port returns `ResultW` in that cycle.
- **Same-cycle read/write to the same index, `RF_BYPASS_EN` undefined:** the read port returns the old value. The hazard unit must then stall decode for one cycle.
- Both read ports may select the same index as each other and as `RdW`. Each port resolves its bypass independently.
- The bypass never applies to index 0, even when `RegWriteW=1` and `RdW=0`.

## Configuration
- `RF_BYPASS_EN` defined:
  - Each read port has a comparator `(RegWriteW && RdW==Ax && Ax≠0)` and a 2:1 mux selecting `ResultW`.
  - The write-first result is visible in the same cycle.
- `RF_BYPASS_EN` undefined:
  - Read data comes purely from storage, so a read sees the pre-write value in the write cycle.
  - No comparator logic is generated.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`;
  - `REG_IDX_W` (5);
  - the `reg_idx_t` and `word_t` typedefs;
  - the constant `REG_ZERO = 0`.
- One sub-module, `regfile_read_port`, is instantiated twice. It holds the index decode, the zero-forcing and the optional bypass mux.
- The write logic and `WrCountW` live in the top module.

## Test plan
1. **Reset values:** assert `reset` asynchronously mid-cycle with `A1D=5`, `A2D=31` → `RD1D=RD2D=0` and `WrCountW=0` before the next edge.
2. **Basic write:** `RegWriteW=1`, `RdW=7`, `ResultW=32'hDEADBEEF`, one edge, then `A1D=7` → `RD1D=32'hDEADBEEF`, `WrCountW=1`.
3. **x0 protection:** write `RdW=0`, `ResultW=32'h12345678` → `RD1D` with `A1D=0` reads 0, and `WrCountW` is unchanged.
4. **Same-cycle read/write:** `regs[3]` holds `32'h1`; write `RdW=3`, `ResultW=32'h2` with `A1D=A2D=3` in the same cycle → both ports read `32'h2` with `RF_BYPASS_EN` and `32'h1` without. After the edge, both read `32'h2`.
5. **Reset during write:** `RegWriteW=1`, `RdW=9`, `ResultW=32'hA5A5A5A5`, with `reset` asserted before the edge → `regs[9]` reads 0 after `reset` deasserts.
6. **Counter saturation:** force 65 537 committed writes → `WrCountW` holds `16'hFFFF` and does not wrap to 0.
